// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the 4x4 keypad scan controller.
// Contents:
//   state_t         - scan FSM states (SCAN, DEBOUNCE, HOLD)
//   KEY_W/ROWS/COLS - key code width and matrix geometry
//   COL_IDLE        - column strobe pattern with no column driven
//   ROW_NONE        - synchronised row pattern with no row pulled low
//   lowest_low_row  - index of the lowest active-low row in a row sample
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam logic [COLS-1:0] COL_IDLE = 4'hF;
  localparam logic [ROWS-1:0] ROW_NONE = 4'hF;

  // When several rows read low at once, the lowest row index wins.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
// Prescaler producing a one-cycle enable every TICK_DIV clock cycles.
// Reusable by any slow poller that must stay on the system clock.
// Parameters:
//   TICK_DIV - clock cycles per tick (>= 2)
// Ports:
//   clkin - system clock, rising edge
//   reset - synchronous, active-high
//   tick  - high for exactly the cycle in which the counter sits at TICK_DIV-1
module scan_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clkin,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decoded from the counter so the tick lines up with the wrap cycle.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan controller for a 4x4 active-low matrix keypad. Walks a single low
// column strobe, synchronises and debounces the rows on a slow tick enable,
// and hands out one key code per press through a valid/ack handshake.
// Optional build macro:
//   KEYPAD_AUTOREPEAT_EN - adds REPEAT_SCANS; a held key re-issues its code
//                          every REPEAT_SCANS ticks while in HOLD.
// Parameters:
//   TICK_DIV       - clkin cycles per scan tick (>= 2)
//   DEBOUNCE_SCANS - consecutive stable ticks to accept press/release (1..15)
// Ports:
//   clkin     - system clock, rising edge
//   reset     - synchronous, active-high
//   row_in    - keypad rows, active-low, asynchronous to clkin
//   col_out   - column strobes, active-low, at most one low
//   key_code  - row*4+col of the accepted key
//   key_valid - key_code holds an unconsumed code
//   key_ack   - consumer accepts key_code
//   overrun   - one-cycle pulse: a press was accepted while key_valid=1 and dropped
//   scan_tick - one-cycle tick pulse for debug/LEDs
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 100
`endif
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             overrun,
  output logic             scan_tick
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic             tick;
  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  rs;
  state_t           state, state_n;
  logic [1:0]       col, col_n;
  logic [1:0]       row_sel, row_sel_n;
  logic [3:0]       dcnt, dcnt_n;
  logic [3:0]       rcnt, rcnt_n;
  logic [KEY_W-1:0] key_code_n;
  logic             key_valid_n;
  logic             overrun_n;
  logic             accept;
  logic             any_low;
  logic [1:0]       low_row;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW         = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_TARGET = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_cnt, rep_cnt_n, rep_next;
`endif

  scan_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clkin(clkin),
    .reset(reset),
    .tick (tick)
  );

  assign scan_tick = tick;
  assign col_out   = COL_IDLE ^ (4'b0001 << col);
  assign any_low   = (rs != ROW_NONE);
  assign low_row   = lowest_low_row(rs);

  // Two-flop synchroniser; rows idle high so reset loads the no-key pattern.
  always_ff @(posedge clkin) begin
    if (reset) begin
      row_meta <= ROW_NONE;
      rs       <= ROW_NONE;
    end else begin
      row_meta <= row_in;
      rs       <= row_meta;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      row_sel   <= 2'd0;
      dcnt      <= 4'd0;
      rcnt      <= 4'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row_sel   <= row_sel_n;
      dcnt      <= dcnt_n;
      rcnt      <= rcnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      overrun   <= overrun_n;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clkin) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_cnt_n;
  end
`endif

  // The FSM only moves on tick cycles; the handshake is serviced every cycle.
  // The column is held while a key is being debounced or held, so the
  // current col doubles as the captured column of the key.
  always_comb begin
    state_n     = state;
    col_n       = col;
    row_sel_n   = row_sel;
    dcnt_n      = dcnt;
    rcnt_n      = rcnt;
    key_code_n  = key_code;
    key_valid_n = key_valid;
    overrun_n   = 1'b0;
    accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_next    = rep_cnt + RW'(1);
`endif

    if (key_valid && key_ack) key_valid_n = 1'b0;

    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            row_sel_n = low_row;
            dcnt_n    = 4'd1;
            if (DB_TARGET == 4'd1) begin
              accept  = 1'b1;
              state_n = HOLD;
              rcnt_n  = 4'd0;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!rs[row_sel]) begin
            dcnt_n = dcnt + 4'd1;
            if (dcnt_n == DB_TARGET) begin
              accept  = 1'b1;
              state_n = HOLD;
              rcnt_n  = 4'd0;
            end
          end else begin
            state_n = SCAN;
            col_n   = col + 2'd1;
          end
        end
        HOLD: begin
          if (!any_low) begin
            rcnt_n = rcnt + 4'd1;
            if (rcnt_n == DB_TARGET) begin
              state_n = SCAN;
              col_n   = col + 2'd1;
            end
          end else begin
            rcnt_n = 4'd0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (!rs[row_sel]) begin
            if (rep_next == REP_TARGET) begin
              accept    = 1'b1;
              rep_cnt_n = '0;
            end else begin
              rep_cnt_n = rep_next;
            end
          end else begin
            rep_cnt_n = '0;
          end
`endif
        end
        default: begin
          state_n = SCAN;
        end
      endcase
`ifdef KEYPAD_AUTOREPEAT_EN
      if (state != HOLD && state_n == HOLD) rep_cnt_n = '0;
`endif
    end

    // A same-cycle ack frees the slot, so the new code loads instead of
    // being dropped.
    if (accept) begin
      if (!key_valid || key_ack) begin
        key_code_n  = {row_sel_n, col};
        key_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Self-checking bench for keypad_scan_ctrl with TICK_DIV=4, DEBOUNCE_SCANS=3.
// A behavioural 4x4 matrix drives row_in from col_out and the pressed key.
// Expected key codes are queued when a press is driven and compared when the
// DUT presents a new code.
module tb_keypad_scan_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;
  logic       scan_tick;

  logic       pressed;
  logic [1:0] pr_row;
  logic [1:0] pr_col;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         ovr_count    = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid;
  logic [3:0] prev_code;

  keypad_scan_ctrl #(
    .TICK_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overrun  (overrun),
    .scan_tick(scan_tick)
  );

  always #5 clkin = ~clkin;

  // Keypad matrix: the pressed key pulls its row low only while its column
  // strobe is driven low.
  always_comb begin
    row_in = 4'hF;
    if (pressed && !col_out[pr_col]) row_in[pr_row] = 1'b0;
  end

  function automatic logic [3:0] colPattern(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic press, input logic [1:0] r,
                               input logic [1:0] c);
    pressed = press;
    pr_row  = r;
    pr_col  = c;
  endtask

  task automatic waitTickHigh(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (scan_tick !== 1'b1 && n < 20);
    if (scan_tick !== 1'b1) checkOutput(tag, scan_tick, 1);
  endtask

  task automatic waitTick();
    waitTickHigh("tick_timeout");
    @(negedge clkin);
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) waitTick();
  endtask

  task automatic waitCol(input int c);
    for (int i = 0; i < 8; i++) begin
      waitTick();
      if (col_out === colPattern(c)) break;
    end
    checkOutput("wait_col", col_out, colPattern(c));
  endtask

  // Scoreboard side: a new code is a rising key_valid or a changed key_code.
  initial begin
    prev_valid = 1'b0;
    prev_code  = 4'd0;
    forever begin
      @(negedge clkin);
      if (overrun === 1'b1) ovr_count++;
      if (key_valid === 1'b1 && (!prev_valid || key_code !== prev_code)) begin
        if (exp_q.size() == 0) checkOutput("sb_unexpected_code", exp_q.size(), 1);
        else                   checkOutput("sb_key_code", key_code, exp_q.pop_front());
      end
      prev_valid = key_valid;
      prev_code  = key_code;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_col;
    int tick_cnt;

    reset   = 1'b1;
    key_ack = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0);

    // Reset state
    repeat (3) @(negedge clkin);
    checkOutput("rst_col_out", col_out, 4'b1110);
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_key_code", key_code, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_scan_tick", scan_tick, 0);
    reset = 1'b0;

    // 1: idle scanning walks the strobe one column per tick
    exp_col = 0;
    for (int i = 0; i < 4; i++) begin
      waitTick();
      exp_col = (exp_col + 1) % 4;
      checkOutput("t1_col_step", col_out, colPattern(exp_col));
    end
    tick_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clkin);
      if (scan_tick === 1'b1) tick_cnt++;
    end
    checkOutput("t1_tick_rate", tick_cnt, 4);
    checkOutput("t1_no_valid", key_valid, 0);

    // 2: key 9 (row 2, col 1) with exact debounce latency and release hold-off
    waitCol(1);
    applyStimulus(1'b1, 2'd2, 2'd1);
    exp_q.push_back(4'd9);
    waitTick();
    checkOutput("t2_col_held", col_out, 4'b1101);
    waitTick();
    checkOutput("t2_not_yet_valid", key_valid, 0);
    waitTick();
    checkOutput("t2_valid", key_valid, 1);
    checkOutput("t2_code", key_code, 9);
    waitTicks(2);
    checkOutput("t2_col_frozen", col_out, 4'b1101);
    applyStimulus(1'b0, 2'd2, 2'd1);
    waitTicks(2);
    checkOutput("t2_release_hold", col_out, 4'b1101);
    waitTick();
    checkOutput("t2_release_scan", col_out, 4'b1011);
    key_ack = 1'b1;
    @(negedge clkin);
    key_ack = 1'b0;
    checkOutput("t2_ack_clears", key_valid, 0);

    // 3: one-tick bounce on row 0 while col 3 is strobed
    waitCol(3);
    applyStimulus(1'b1, 2'd0, 2'd3);
    waitTick();
    applyStimulus(1'b0, 2'd0, 2'd3);
    waitTick();
    checkOutput("t3_back_to_col0", col_out, 4'b1110);
    checkOutput("t3_no_valid", key_valid, 0);
    waitTicks(3);
    checkOutput("t3_still_no_valid", key_valid, 0);

    // 4: second press without ack is dropped with a single overrun pulse
    applyStimulus(1'b1, 2'd1, 2'd1);
    exp_q.push_back(4'd5);
    waitTicks(8);
    applyStimulus(1'b0, 2'd1, 2'd1);
    waitTicks(4);
    applyStimulus(1'b1, 2'd1, 2'd2);
    waitTicks(8);
    checkOutput("t4_code_kept", key_code, 5);
    checkOutput("t4_valid_kept", key_valid, 1);
    checkOutput("t4_overrun_once", ovr_count, 1);
    applyStimulus(1'b0, 2'd1, 2'd2);
    waitTicks(4);
    key_ack = 1'b1;
    @(negedge clkin);
    key_ack = 1'b0;
    checkOutput("t4_ack_clears", key_valid, 0);

    // 5: ack in the same cycle a new key is accepted
    applyStimulus(1'b1, 2'd0, 2'd3);
    exp_q.push_back(4'd3);
    waitTicks(8);
    applyStimulus(1'b0, 2'd0, 2'd3);
    waitTicks(4);
    checkOutput("t5_first_valid", key_valid, 1);
    waitCol(2);
    applyStimulus(1'b1, 2'd3, 2'd2);
    exp_q.push_back(4'd14);
    waitTicks(2);
    waitTickHigh("t5_tick_timeout");
    key_ack = 1'b1;
    @(negedge clkin);
    key_ack = 1'b0;
    checkOutput("t5_valid_stays", key_valid, 1);
    checkOutput("t5_code_updates", key_code, 14);
    checkOutput("t5_no_overrun", overrun, 0);
    applyStimulus(1'b0, 2'd3, 2'd2);
    waitTicks(4);

    // 6: reset while debouncing discards all progress
    waitCol(2);
    applyStimulus(1'b1, 2'd2, 2'd2);
    waitTick();
    checkOutput("t6_col_held", col_out, 4'b1011);
    reset = 1'b1;
    @(negedge clkin);
    checkOutput("t6_rst_col", col_out, 4'b1110);
    checkOutput("t6_rst_valid", key_valid, 0);
    checkOutput("t6_rst_overrun", overrun, 0);
    checkOutput("t6_rst_tick", scan_tick, 0);
    applyStimulus(1'b0, 2'd2, 2'd2);
    @(negedge clkin);
    reset = 1'b0;
    waitTick();
    checkOutput("t6_scan_resumes", col_out, 4'b1101);
    checkOutput("t6_no_valid", key_valid, 0);

    waitTicks(2);
    checkOutput("sb_drained", exp_q.size(), 0);
    checkOutput("overrun_total", ovr_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
